// File: rtl/oric_tape_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : oric_tape_tx
//  Description : Oric cassette fast-format transmitter. Serialises one byte per
//                frame (start '0', 8 data bits LSB first, odd-style parity,
//                STOP_BITS '1' cells) into the K7_TAPEIN waveform, paced by
//                the 1 MHz CPU enable and gated by the motor relay line.
//  Revision    : 1.0 - initial release
// ============================================================================
module oric_tape_tx #(
    parameter int HALF      = 208,
    parameter int STOP_BITS = 4
) (
    input  logic        CLK_IN,
    input  logic        RESET,
    input  logic        ena_1mhz,
    input  logic        motor,
    input  logic [7:0]  din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic        tape_out,
    output logic        busy,
    output logic [15:0] bytes_sent
);

    // Cells per frame: start + 8 data + parity + stop cells.
    localparam int c_NCELLS = 10 + STOP_BITS;
    localparam int c_CNT_W  = $clog2(2 * HALF + 1);
    localparam int c_IDX_W  = $clog2(c_NCELLS);

    localparam logic [c_CNT_W-1:0] c_HALF = c_CNT_W'(HALF);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(2 * HALF);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_NCELLS - 1);
    localparam logic [c_IDX_W-1:0] c_IONE = c_IDX_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt,   w_cnt_nxt;
    logic [c_IDX_W-1:0]   r_idx,   w_idx_nxt;
    logic [c_NCELLS-1:0]  r_frame, w_frame_nxt;
    logic                 r_tape,  w_tape_nxt;
    logic [15:0]          r_bytes, w_bytes_nxt;

    logic                 w_accept;
    logic                 w_tick;
    logic [c_CNT_W-1:0]   w_cnt_inc;
    logic [c_CNT_W-1:0]   w_low_len;

    // Ready only when idle with the tape running; held low while in reset.
    assign din_ready  = (r_state == ST_IDLE) & motor & ~RESET;
    assign busy       = (r_state != ST_IDLE);
    assign tape_out   = r_tape;
    assign bytes_sent = r_bytes;

    assign w_accept  = din_valid & din_ready;
    // A stopped motor freezes all waveform timing.
    assign w_tick    = ena_1mhz & motor;
    assign w_cnt_inc = r_cnt + c_ONE;
    // Bit 0 of the frame register is always the cell being sent.
    assign w_low_len = r_frame[0] ? c_HALF : c_FULL;

    // State and datapath registers.
    always_ff @(posedge CLK_IN or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_frame <= '0;
            r_tape  <= 1'b0;
            r_bytes <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_frame <= w_frame_nxt;
            r_tape  <= w_tape_nxt;
            r_bytes <= w_bytes_nxt;
        end
    end

    // Next-state logic: high half-cell, then low for one or two half-cells.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_frame_nxt = r_frame;
        w_tape_nxt  = r_tape;
        w_bytes_nxt = r_bytes;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    // Whole frame preloaded: stops, parity, data, start.
                    w_frame_nxt = {{STOP_BITS{1'b1}}, ~(^din), din, 1'b0};
                    w_state_nxt = ST_HIGH;
                    w_tape_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            end

            ST_HIGH: begin
                if (w_tick) begin
                    if (w_cnt_inc == c_HALF) begin
                        w_state_nxt = ST_LOW;
                        w_tape_nxt  = 1'b0;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end

            ST_LOW: begin
                if (w_tick) begin
                    if (w_cnt_inc == w_low_len) begin
                        w_cnt_nxt = '0;
                        if (r_idx == c_LAST) begin
                            w_state_nxt = ST_IDLE;
                            w_tape_nxt  = 1'b0;
                            w_idx_nxt   = '0;
                            w_bytes_nxt = r_bytes + 16'd1;
                        end else begin
                            w_state_nxt = ST_HIGH;
                            w_tape_nxt  = 1'b1;
                            w_idx_nxt   = r_idx + c_IONE;
                            w_frame_nxt = {1'b1, r_frame[c_NCELLS-1:1]};
                        end
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_tape_nxt  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_oric_tape_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_oric_tape_tx
//  Description : Directed self-checking bench for oric_tape_tx. A monitor
//                records high/low run lengths (in counted ticks) and busy
//                duration per frame; checks compare them with the cell timing
//                expected for each byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_oric_tape_tx;

    localparam int c_HALF = 208;
    localparam int c_STOP = 4;
    localparam int c_RUNS = 2 * (10 + c_STOP);

    logic        CLK_IN    = 1'b0;
    logic        RESET     = 1'b1;
    logic        ena_1mhz  = 1'b0;
    logic        motor     = 1'b0;
    logic [7:0]  din       = 8'h00;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic        tape_out;
    logic        busy;
    logic [15:0] bytes_sent;

    int n_checks = 0;
    int n_errors = 0;
    int ena_div  = 1;

    int runs[$];
    int frame_ticks[$];
    int run_len   = 0;
    int tick_acc  = 0;
    int idle_cnt  = 0;
    int acc_cnt   = 0;
    logic prev_busy = 1'b0;
    logic prev_tape = 1'b0;

    logic [7:0] seq [3];
    int   got;
    int   cyc;
    logic acc;

    oric_tape_tx #(
        .HALF      (c_HALF),
        .STOP_BITS (c_STOP)
    ) u_dut (
        .CLK_IN     (CLK_IN),
        .RESET      (RESET),
        .ena_1mhz   (ena_1mhz),
        .motor      (motor),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .tape_out   (tape_out),
        .busy       (busy),
        .bytes_sent (bytes_sent)
    );

    always #5 CLK_IN = ~CLK_IN;

    // 1 MHz enable: one pulse every ena_div clocks.
    initial begin : ena_gen
        int k;
        k = 0;
        forever begin
            @(posedge CLK_IN);
            #1;
            k++;
            ena_1mhz = ((k % ena_div) == 0);
        end
    end

    // Run-length monitor sampled on the falling edge.
    always @(negedge CLK_IN) begin
        if (din_valid && din_ready) acc_cnt++;
        if (!busy) idle_cnt++;
        if (busy) begin
            if (!prev_busy) begin
                run_len  = 0;
                tick_acc = 0;
            end else if (tape_out != prev_tape) begin
                runs.push_back(run_len);
                run_len = 0;
            end
            if (ena_1mhz && motor) run_len++;
            if (ena_1mhz) tick_acc++;
        end else if (prev_busy) begin
            runs.push_back(run_len);
            frame_ticks.push_back(tick_acc);
            run_len  = 0;
            tick_acc = 0;
        end
        prev_busy = busy;
        prev_tape = tape_out;
    end

    task automatic check_val(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
        end
    endtask

    task automatic clear_mon();
        runs.delete();
        frame_ticks.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        din       = b;
        din_valid = 1'b1;
        while (!din_ready && n < 1000) begin
            @(posedge CLK_IN);
            #1;
            n++;
        end
        if (n >= 1000) check_val("ready_timeout", 32'(din_ready), 1);
        @(posedge CLK_IN);
        #1;
        din_valid = 1'b0;
        din       = ~b;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(posedge CLK_IN);
            #1;
            n++;
        end
        if (busy) check_val("idle_timeout", 32'(busy), 0);
        @(negedge CLK_IN);
        @(posedge CLK_IN);
        #1;
    endtask

    // Expected cells: start '0', data LSB first, parity = 1^xor(data), stop '1's.
    task automatic check_frame(input logic [7:0] b, input int base, input int fidx, input int exp_ticks);
        logic bitv;
        for (int c = 0; c < 10 + c_STOP; c++) begin
            if (c == 0)      bitv = 1'b0;
            else if (c <= 8) bitv = b[c-1];
            else if (c == 9) bitv = ~(^b);
            else             bitv = 1'b1;
            check_val($sformatf("f%0d_cell%0d_hi", fidx, c), runs[base + 2*c], c_HALF);
            check_val($sformatf("f%0d_cell%0d_lo", fidx, c), runs[base + 2*c + 1],
                      bitv ? c_HALF : 2 * c_HALF);
        end
        check_val($sformatf("f%0d_ticks", fidx), frame_ticks[fidx], exp_ticks);
    endtask

    initial begin
        seq[0] = 8'h16;
        seq[1] = 8'h16;
        seq[2] = 8'h24;

        // Reset values, with motor running.
        RESET = 1'b1;
        motor = 1'b1;
        repeat (3) @(posedge CLK_IN);
        #1;
        check_val("rst_tape",  32'(tape_out),   0);
        check_val("rst_ready", 32'(din_ready),  0);
        check_val("rst_busy",  32'(busy),       0);
        check_val("rst_bytes", 32'(bytes_sent), 0);
        RESET = 1'b0;
        @(posedge CLK_IN);
        #1;
        check_val("idle_ready", 32'(din_ready), 1);

        // 0x00: 37H = 7696 ticks.
        clear_mon();
        send_byte(8'h00);
        wait_idle(20000);
        check_val("f00_nruns", runs.size(), c_RUNS);
        check_frame(8'h00, 0, 0, 7696);
        check_val("bytes_1", 32'(bytes_sent), 1);

        // 0x01 with a slower enable: still 37H ticks.
        ena_div = 2;
        clear_mon();
        send_byte(8'h01);
        wait_idle(40000);
        ena_div = 1;
        check_val("f01_nruns", runs.size(), c_RUNS);
        check_frame(8'h01, 0, 0, 7696);
        check_val("bytes_2", 32'(bytes_sent), 2);

        // Back-to-back 0x16, 0x16, 0x24 with din_valid held high (35H each).
        clear_mon();
        idle_cnt  = 0;
        acc_cnt   = 0;
        got       = 0;
        cyc       = 0;
        din       = seq[0];
        din_valid = 1'b1;
        while (bytes_sent != 16'd5 && cyc < 30000) begin
            acc = din_ready && din_valid;
            @(posedge CLK_IN);
            #1;
            cyc++;
            if (acc) begin
                got++;
                if (got < 3) din = seq[got];
                else         din_valid = 1'b0;
            end
        end
        din_valid = 1'b0;
        check_val("b2b_timeout", 32'(cyc < 30000), 1);
        check_val("b2b_accepts", acc_cnt, 3);
        check_val("b2b_idle_cycles", idle_cnt, 3);
        check_val("bytes_5", 32'(bytes_sent), 5);
        @(negedge CLK_IN);
        @(posedge CLK_IN);
        #1;
        check_val("b2b_nruns", runs.size(), 3 * c_RUNS);
        check_frame(8'h16, 0,          0, 7280);
        check_frame(8'h16, c_RUNS,     1, 7280);
        check_frame(8'h24, 2 * c_RUNS, 2, 7280);

        // 0xFF with a 1000-tick motor stop inside data cell 3 (1456..1664).
        clear_mon();
        send_byte(8'hFF);
        repeat (1600) @(posedge CLK_IN);
        #1;
        check_val("pause_tape_before", 32'(tape_out), 1);
        motor = 1'b0;
        repeat (1000) @(posedge CLK_IN);
        #1;
        check_val("pause_tape_frozen", 32'(tape_out),  1);
        check_val("pause_busy",        32'(busy),      1);
        check_val("pause_ready",       32'(din_ready), 0);
        motor = 1'b1;
        wait_idle(20000);
        check_val("fff_nruns", runs.size(), c_RUNS);
        check_frame(8'hFF, 0, 0, 7032);
        check_val("bytes_6", 32'(bytes_sent), 6);

        // Motor low in IDLE blocks the transfer; raising it accepts at once.
        motor     = 1'b0;
        din       = 8'h5A;
        din_valid = 1'b1;
        repeat (10) @(posedge CLK_IN);
        #1;
        check_val("mot0_ready", 32'(din_ready),  0);
        check_val("mot0_busy",  32'(busy),       0);
        check_val("mot0_bytes", 32'(bytes_sent), 6);
        motor = 1'b1;
        #1;
        check_val("mot1_ready", 32'(din_ready), 1);
        @(posedge CLK_IN);
        #1;
        check_val("mot1_busy", 32'(busy), 1);
        din_valid = 1'b0;

        // 0x5A parity cell ('1') spans ticks 4784..5200; reset at 4884.
        repeat (4884) @(posedge CLK_IN);
        #1;
        check_val("par_tape",  32'(tape_out),   1);
        check_val("par_busy",  32'(busy),       1);
        check_val("par_bytes", 32'(bytes_sent), 6);
        #2;
        RESET = 1'b1;
        #1;
        check_val("arst_tape",  32'(tape_out),   0);
        check_val("arst_busy",  32'(busy),       0);
        check_val("arst_ready", 32'(din_ready),  0);
        check_val("arst_bytes", 32'(bytes_sent), 0);
        @(posedge CLK_IN);
        #1;
        RESET = 1'b0;
        repeat (2) @(posedge CLK_IN);
        #1;
        check_val("post_bytes", 32'(bytes_sent), 0);
        check_val("post_ready", 32'(din_ready),  1);
        check_val("post_busy",  32'(busy),       0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
